zet_fetch_queue: RTL

Instruction prefetch queue and byte producer feeding the decode stage. Fetches 16-bit code words from memory over a Wishbone master port at CS:IP and buffers the bytes in a small FIFO. Presents one byte at a time through the instruction_o / instruction_valid_o / next_instruction_i handshake, together with the CS:IP of the head byte. Supports a flush that redirects fetch to a new CS:IP, used for jumps, calls and interrupts.

---
 rtl/zet_fetch_queue.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/zet_fetch_queue.sv
// Instruction prefetch queue: fetches 16-bit code words at CS:IP over a
// Wishbone master port and hands bytes to the decoder one at a time.
module zet_fetch_queue #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] RESET_CS   = 16'hF000,
    parameter logic [15:0] RESET_IP   = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [15:0] new_cs_i,
    input  logic [15:0] new_ip_i,
    output logic [18:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [7:0]  instruction_o,
    output logic        instruction_valid_o,
    input  logic        next_instruction_i,
    output logic [15:0] instruction_cs_o,
    output logic [15:0] instruction_ip_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_TWO   = DEPTH_LOG2'(2);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_TWO   = CW'(2);
    // Highest fill level that still leaves room for a full word.
    localparam logic [CW-1:0]         MAX_ISSUE = CW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, BUS, DISCARD} state_t;

    state_t                 state_reg, state_next;
    logic                   cyc_reg, cyc_next;
    logic                   stb_reg, stb_next;
    logic [18:0]            adr_reg, adr_next;
    logic [1:0]             sel_reg, sel_next;

    logic [7:0]             mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [15:0]            fetch_cs_reg, fetch_ip_reg;
    logic [15:0]            head_cs_reg, head_ip_reg;

    logic [19:0]            phys;
    logic                   odd;
    logic                   push_en;
    logic                   pop_en;
    logic [CW-1:0]          cnt_push, cnt_pop;
    logic [DEPTH_LOG2-1:0]  ptr_push;
    logic [15:0]            ip_push;
    logic [7:0]             byte_first;

    assign phys       = {fetch_cs_reg, 4'b0000} + {4'b0000, fetch_ip_reg};
    assign odd        = fetch_ip_reg[0];
    // Only a live (non-discarded, non-flushed) acknowledge enters the queue.
    assign push_en    = (state_reg == BUS) && wb_ack_i && !flush_i;
    assign pop_en     = (count_reg != '0) && next_instruction_i && !flush_i;
    assign byte_first = odd ? wb_dat_i[15:8] : wb_dat_i[7:0];
    assign cnt_push   = push_en ? (odd ? CNT_ONE : CNT_TWO) : '0;
    assign cnt_pop    = pop_en ? CNT_ONE : '0;
    assign ptr_push   = push_en ? (odd ? PTR_ONE : PTR_TWO) : '0;
    assign ip_push    = push_en ? (odd ? 16'd1 : 16'd2) : 16'd0;

    assign wb_cyc_o            = cyc_reg;
    assign wb_stb_o            = stb_reg;
    assign wb_adr_o            = adr_reg;
    assign wb_sel_o            = sel_reg;
    assign instruction_o       = mem_reg[rd_ptr_reg];
    assign instruction_valid_o = (count_reg != '0);
    assign instruction_cs_o    = head_cs_reg;
    assign instruction_ip_o    = head_ip_reg;

    // Next-state and registered bus outputs of the fetch FSM.
    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        stb_next   = stb_reg;
        adr_next   = adr_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (!flush_i && (count_reg <= MAX_ISSUE)) begin
                    state_next = BUS;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    adr_next   = phys[19:1];
                    sel_next   = odd ? 2'b10 : 2'b11;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    state_next = IDLE;
                    cyc_next   = 1'b0;
                    stb_next   = 1'b0;
                end else if (flush_i) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (wb_ack_i) begin
                    state_next = IDLE;
                    cyc_next   = 1'b0;
                    stb_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
                stb_next   = 1'b0;
            end
        endcase
    end

    // FSM state and Wishbone output registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            adr_reg   <= '0;
            sel_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            adr_reg   <= adr_next;
            sel_reg   <= sel_next;
        end
    end

    // Queue pointers, occupancy and the fetch / head CS:IP trackers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_cs_reg <= RESET_CS;
            fetch_ip_reg <= RESET_IP;
            head_cs_reg  <= RESET_CS;
            head_ip_reg  <= RESET_IP;
        end else if (flush_i) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_cs_reg <= new_cs_i;
            fetch_ip_reg <= new_ip_i;
            head_cs_reg  <= new_cs_i;
            head_ip_reg  <= new_ip_i;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + ptr_push;
            fetch_ip_reg <= fetch_ip_reg + ip_push;
            count_reg    <= count_reg + cnt_push - cnt_pop;
            if (pop_en) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                head_ip_reg <= head_ip_reg + 16'd1;
            end
        end
    end

    // Byte storage; an even fetch writes two consecutive slots, odd writes one.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else if (push_en) begin
            mem_reg[wr_ptr_reg] <= byte_first;
            if (!odd) begin
                mem_reg[wr_ptr_reg + PTR_ONE] <= wb_dat_i[15:8];
            end
        end
    end

endmodule
